// File: rtl/pe8_pkg.sv
// Shared types and sizing for the 8-lane PE operand sequencer.
// Holds the FSM state encoding and the packed PE configuration word.
package pe8_pkg;
   localparam int LANES    = 8;
   localparam int DATA_W   = 32;
   localparam int SLOTS    = 2 * LANES;
   localparam int M_SEL_W  = 20;
   localparam int OP_W     = 2;
   localparam int ADDSUB_W = 2;
   localparam int ROUND_W  = 3;
   localparam int BEAT_W   = 4;
   localparam int WAIT_W   = 4;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [M_SEL_W-1:0]  m_sel;
      logic [OP_W-1:0]     op_type;
      logic [ADDSUB_W-1:0] addsub_op;
      logic                use_int;
      logic                tininess;
      logic [ROUND_W-1:0]  rounding;
   } cfg_t;
endpackage

// File: rtl/pe8_driver_if.sv
// Host and PE-side signal bundle for pe8_driver.
// master is the driver's own view; slave is the host/PE environment view.
interface pe8_driver_if;
   import pe8_pkg::*;

   logic                      io_in_valid;
   logic                      io_in_ready;
   logic [DATA_W-1:0]         io_in_x;
   logic [DATA_W-1:0]         io_in_y;

   logic                      io_cfg_valid;
   logic                      io_cfg_ready;
   logic [M_SEL_W-1:0]        io_cfg_m_sel;
   logic [OP_W-1:0]           io_cfg_op_type;
   logic [ADDSUB_W-1:0]       io_cfg_addsub_op;
   logic                      io_cfg_use_int;
   logic                      io_cfg_tininess;
   logic [ROUND_W-1:0]        io_cfg_rounding;

   logic [SLOTS*DATA_W-1:0]   io_pe_x;
   logic [SLOTS*DATA_W-1:0]   io_pe_y;
   logic [M_SEL_W-1:0]        io_pe_m_sel;
   logic [OP_W-1:0]           io_pe_op_type;
   logic [ADDSUB_W-1:0]       io_pe_addsub_op;
   logic                      io_pe_use_int;
   logic                      io_pe_tininess;
   logic [ROUND_W-1:0]        io_pe_rounding;
   logic                      io_pe_issue;
   logic [DATA_W-1:0]         io_pe_out_0;
   logic [DATA_W-1:0]         io_pe_out_1;

   logic                      io_res_valid;
   logic                      io_res_ready;
   logic [DATA_W-1:0]         io_res_0;
   logic [DATA_W-1:0]         io_res_1;
   logic                      io_busy;

   modport master (
      input  io_in_valid, io_in_x, io_in_y,
      input  io_cfg_valid, io_cfg_m_sel, io_cfg_op_type, io_cfg_addsub_op,
      input  io_cfg_use_int, io_cfg_tininess, io_cfg_rounding,
      input  io_pe_out_0, io_pe_out_1, io_res_ready,
      output io_in_ready, io_cfg_ready,
      output io_pe_x, io_pe_y, io_pe_m_sel, io_pe_op_type, io_pe_addsub_op,
      output io_pe_use_int, io_pe_tininess, io_pe_rounding, io_pe_issue,
      output io_res_valid, io_res_0, io_res_1, io_busy
   );

   modport slave (
      output io_in_valid, io_in_x, io_in_y,
      output io_cfg_valid, io_cfg_m_sel, io_cfg_op_type, io_cfg_addsub_op,
      output io_cfg_use_int, io_cfg_tininess, io_cfg_rounding,
      output io_pe_out_0, io_pe_out_1, io_res_ready,
      input  io_in_ready, io_cfg_ready,
      input  io_pe_x, io_pe_y, io_pe_m_sel, io_pe_op_type, io_pe_addsub_op,
      input  io_pe_use_int, io_pe_tininess, io_pe_rounding, io_pe_issue,
      input  io_res_valid, io_res_0, io_res_1, io_busy
   );
endinterface

// File: rtl/pe8_operand_buffer.sv
// 16-slot X/Y operand store; slot k holds lane k>>1, input k&1.
// Outputs are the flat packed operand buses presented to the PE.
module pe8_operand_buffer
   import pe8_pkg::*;
(
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_wr_en,
   input  logic [BEAT_W-1:0]       i_wr_idx,
   input  logic [DATA_W-1:0]       i_x,
   input  logic [DATA_W-1:0]       i_y,
   output logic [SLOTS*DATA_W-1:0] o_x,
   output logic [SLOTS*DATA_W-1:0] o_y
);

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic [DATA_W-1:0] r_x;
      logic [DATA_W-1:0] r_y;
      logic              w_sel;

      assign w_sel = i_wr_en && (i_wr_idx == BEAT_W'(gi));

      always_ff @(posedge i_clock) begin
         if (i_reset) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_sel) begin
            r_x <= i_x;
            r_y <= i_y;
         end
      end

      assign o_x[gi*DATA_W +: DATA_W] = r_x;
      assign o_y[gi*DATA_W +: DATA_W] = r_y;
   end

endmodule

// File: rtl/pe8_driver.sv
// Operand sequencer / result collector for the 8-lane PE: fills one job,
// issues it, waits the fixed PE latency, then returns both results.
module pe8_driver
   import pe8_pkg::*;
#(
   parameter int PE_LATENCY = 4
)(
   input  logic         clock,
   input  logic         reset,
   pe8_driver_if.master bus
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PE_LATENCY - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SLOTS - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [BEAT_W-1:0]   r_beat_cnt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   cfg_t                r_cfg;
   cfg_t                w_cfg_in;
   logic [DATA_W-1:0]   r_res_0;
   logic [DATA_W-1:0]   r_res_1;

   logic                w_in_ready;
   logic                w_cfg_ready;
   logic                w_beat_acc;
   logic                w_cfg_acc;
   logic                w_last_beat;
   logic                w_wait_done;
   logic                w_issue;
   logic                w_res_valid;
   logic                w_busy;

   assign w_in_ready  = (r_state == ST_FILL);
   assign w_cfg_ready = w_in_ready && (r_beat_cnt == '0);
   assign w_beat_acc  = bus.io_in_valid && w_in_ready;
   assign w_cfg_acc   = bus.io_cfg_valid && w_cfg_ready;
   assign w_last_beat = w_beat_acc && (r_beat_cnt == BEAT_LAST);
   assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == WAIT_LAST);

   assign w_cfg_in = {bus.io_cfg_m_sel, bus.io_cfg_op_type, bus.io_cfg_addsub_op,
                      bus.io_cfg_use_int, bus.io_cfg_tininess, bus.io_cfg_rounding};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_res_valid  = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (w_last_beat) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_issue      = 1'b1;
            w_busy       = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_busy = 1'b1;
            if (w_wait_done) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_busy      = 1'b1;
            w_res_valid = 1'b1;
            if (bus.io_res_ready) begin
               w_state_next = ST_FILL;
            end
         end
         default: begin
            w_state_next = ST_FILL;
         end
      endcase
   end

   // Beat counter wraps 15 -> 0 on the last beat, so each job starts at slot 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_beat_cnt <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_beat_acc) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
         end
         if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cfg <= '0;
      end else if (w_cfg_acc) begin
         r_cfg <= w_cfg_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_res_0 <= '0;
         r_res_1 <= '0;
      end else if (w_wait_done) begin
         r_res_0 <= bus.io_pe_out_0;
         r_res_1 <= bus.io_pe_out_1;
      end
   end

   pe8_operand_buffer u_operand_buffer (
      .i_clock  (clock),
      .i_reset  (reset),
      .i_wr_en  (w_beat_acc),
      .i_wr_idx (r_beat_cnt),
      .i_x      (bus.io_in_x),
      .i_y      (bus.io_in_y),
      .o_x      (bus.io_pe_x),
      .o_y      (bus.io_pe_y)
   );

   assign bus.io_in_ready     = w_in_ready;
   assign bus.io_cfg_ready    = w_cfg_ready;
   assign bus.io_pe_m_sel     = r_cfg.m_sel;
   assign bus.io_pe_op_type   = r_cfg.op_type;
   assign bus.io_pe_addsub_op = r_cfg.addsub_op;
   assign bus.io_pe_use_int   = r_cfg.use_int;
   assign bus.io_pe_tininess  = r_cfg.tininess;
   assign bus.io_pe_rounding  = r_cfg.rounding;
   assign bus.io_pe_issue     = w_issue;
   assign bus.io_res_valid    = w_res_valid;
   assign bus.io_res_0        = r_res_0;
   assign bus.io_res_1        = r_res_1;
   assign bus.io_busy         = w_busy;

endmodule
